// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states
//   GuardCycles : cycles to wait for the transmitter to go busy after a write
//   CntWidth    : width of the issued-byte counter
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitDone
  } arb_state_e;

  localparam int unsigned GuardCycles = 16;
  localparam int unsigned GuardWidth  = $clog2(GuardCycles);
  localparam int unsigned CntWidth    = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational one-hot winner select for the UART transmit arbiter.
// Default build: round-robin, search starts one above last_i and wraps.
// With UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the last_i port does not exist.
// Ports:
//   req_i  : request vector
//   last_i : index of the previous winner (round-robin build only)
//   gnt_o  : one-hot winner, zero when req_i is zero
//   idx_o  : binary index of the winner
module uart_rr_pick #(
  parameter int unsigned NB_REQ = 4
) (
  input  logic [NB_REQ-1:0]         req_i,
`ifndef UART_TX_ARB_FIXED_PRIO_EN
  input  logic [$clog2(NB_REQ)-1:0] last_i,
`endif
  output logic [NB_REQ-1:0]         gnt_o,
  output logic [$clog2(NB_REQ)-1:0] idx_o
);

  localparam int unsigned IdxWidth = $clog2(NB_REQ);

  logic        found;
  int unsigned cand;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = i;
      if (!found && req_i[IdxWidth'(cand)]) begin
        found                  = 1'b1;
        gnt_o[IdxWidth'(cand)] = 1'b1;
        idx_o                  = IdxWidth'(cand);
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    // Offsets 1..NB_REQ visit every index once, ending on last_i itself.
    for (int unsigned i = 1; i <= NB_REQ; i++) begin
      cand = (32'(last_i) + i) % NB_REQ;
      if (!found && req_i[IdxWidth'(cand)]) begin
        found                  = 1'b1;
        gnt_o[IdxWidth'(cand)] = 1'b1;
        idx_o                  = IdxWidth'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NB_REQ byte requesters onto a single UART transmitter write port.
// One byte per grant: latch winner's byte, strobe it once, wait for the
// transmitter to go busy (i_mty low) and then idle again before re-arbitrating.
// If the transmitter never goes busy, a 16-cycle guard returns to idle.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed-priority arbitration
// (lowest index wins); otherwise round-robin.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req        : per-requester request
//   i_data       : requester k byte at [k*WIDTH_DATA +: WIDTH_DATA]
//   i_mty        : transmitter idle/empty, high = can accept a byte
//   o_ack        : one-cycle one-hot pulse, byte of requester k taken
//   o_grant      : one-hot transmitter owner, zero when idle
//   o_we, o_data : transmitter write strobe and byte
//   o_cnt        : bytes issued since reset, wraps
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned NB_REQ     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NB_REQ-1:0]            i_req,
  input  logic [NB_REQ*WIDTH_DATA-1:0] i_data,
  input  logic                         i_mty,
  output logic [NB_REQ-1:0]            o_ack,
  output logic [NB_REQ-1:0]            o_grant,
  output logic                         o_we,
  output logic [WIDTH_DATA-1:0]        o_data,
  output logic [CntWidth-1:0]          o_cnt
);

  localparam int unsigned IdxWidth = $clog2(NB_REQ);

  arb_state_e             state_q;
  logic [GuardWidth-1:0]  guard_q;
  logic [NB_REQ-1:0]      pick_gnt;
  logic [IdxWidth-1:0]    pick_idx;
  logic [WIDTH_DATA-1:0]  pick_data;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  logic [IdxWidth-1:0]    last_q;
`endif

  uart_rr_pick #(
    .NB_REQ (NB_REQ)
  ) u_pick (
    .req_i  (i_req),
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    .last_i (last_q),
`endif
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_comb begin
    pick_data = i_data[pick_idx*WIDTH_DATA +: WIDTH_DATA];
  end

  // o_we/o_ack are set on the IDLE->ISSUE transition so that they are high
  // exactly during the ISSUE cycle; o_cnt is bumped on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      guard_q <= '0;
      o_grant <= '0;
      o_ack   <= '0;
      o_we    <= 1'b0;
      o_data  <= '0;
      o_cnt   <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      last_q  <= IdxWidth'(NB_REQ - 1);
`endif
    end else begin
      o_we  <= 1'b0;
      o_ack <= '0;
      case (state_q)
        StIdle: begin
          if (|i_req && i_mty) begin
            o_grant <= pick_gnt;
            o_ack   <= pick_gnt;
            o_we    <= 1'b1;
            o_data  <= pick_data;
            o_cnt   <= o_cnt + 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_q  <= pick_idx;
`endif
            state_q <= StIssue;
          end
        end
        StIssue: begin
          guard_q <= '0;
          state_q <= StWaitStart;
        end
        StWaitStart: begin
          if (!i_mty) begin
            state_q <= StWaitDone;
          end else if (guard_q == GuardWidth'(GuardCycles - 1)) begin
            // Transmitter never took the byte; give up without rewriting.
            o_grant <= '0;
            state_q <= StIdle;
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (i_mty) begin
            o_grant <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mty;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0] ack;
  logic [N-1:0] grant;
  logic         we;
  logic [W-1:0] odata;
  logic [15:0]  cnt;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [W-1:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  int          tx_mode = 0;   // 1: busy one cycle after o_we, idle 10 later; else always idle
  logic [15:0] exp_cnt = '0;
  logic        preload = 1'b0;
  logic        rst_q = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .WIDTH_DATA (W),
    .NB_REQ     (N)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_data  (data),
    .i_mty   (mty),
    .o_ack   (ack),
    .o_grant (grant),
    .o_we    (we),
    .o_data  (odata),
    .o_cnt   (cnt)
  );

  always @(posedge clk) begin
    rst_q <= rst;
    if (!rst && we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model
  initial begin : tx_model
    mty = 1'b1;
    forever begin
      @(negedge clk);
      if (we && tx_mode == 1) begin
        @(negedge clk);
        mty = 1'b0;
        repeat (10) @(negedge clk);
        mty = 1'b1;
      end
    end
  end

  // Scoreboard: pop one expected entry per write strobe
  initial begin : monitor
    logic cnt_pend;
    exp_t e;
    cnt_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        exp_cnt  = '0;
        cnt_pend = 1'b0;
      end else begin
        if (preload) exp_cnt = 16'hFFFF;
        if (cnt_pend) begin
          check("o_cnt", 32'(cnt), 32'(exp_cnt));
          cnt_pend = 1'b0;
        end
        if (we) begin
          check("ack_onehot", 32'($onehot(ack)), 1);
          if (sb_q.size() == 0) begin
            check("unexpected_we", 0, 1);
          end else begin
            e = sb_q.pop_front();
            check("ack", 32'(ack), 32'(e.ack));
            check("data", 32'(odata), 32'(e.data));
            check("grant", 32'(grant), 32'(e.ack));
          end
          exp_cnt  = exp_cnt + 16'd1;
          cnt_pend = 1'b1;
        end else if (ack != '0) begin
          check("ack_without_we", 32'(ack), 0);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_we(input string tag, output int waited);
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (we) break;
      if (waited >= 200) begin
        check({tag, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  function automatic exp_t mk_exp(input int idx);
    exp_t e;
    e.ack      = '0;
    e.ack[idx] = 1'b1;
    e.data     = data[idx*W +: W];
    return e;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    int w;
    int w0;
    int n;
    int idx;
    data = {8'hD4, 8'hC3, 8'hB2, 8'hA5};

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_we", 32'(we), 0);
    check("rst_data", 32'(odata), 0);
    check("rst_cnt", 32'(cnt), 0);

    // Single request, transmitter always idle
    tx_mode = 2;
    sb_q.push_back(mk_exp(0));
    req = 4'b0001;
    wait_we("single", w);
    req = '0;
    check("single_latency", w, 1);
    repeat (20) @(negedge clk);
    check("single_cnt", 32'(cnt), 1);
    check("single_sb_empty", sb_q.size(), 0);

    // Guard: transmitter never goes busy
    do_reset();
    tx_mode = 2;
    sb_q.push_back(mk_exp(0));
    req = 4'b0001;
    wait_we("guard", w);
    w0  = we_cnt;  // this pulse is counted at the next posedge
    req = 4'b0011;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    sb_q.push_back(mk_exp(0));
`else
    sb_q.push_back(mk_exp(1));
`endif
    // ISSUE + 16 WAIT_START cycles, grant clears on the 17th cycle after o_we
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (grant == '0) break;
    end
    check("guard_cycles", n, 17);
    check("guard_one_we", we_cnt - w0, 1);
    wait_we("guard_next", w);
    req = '0;
    check("guard_next_latency", w, 1);
    repeat (20) @(negedge clk);
    check("guard_sb_empty", sb_q.size(), 0);

    // All requesters active with a handshaking transmitter
    do_reset();
    tx_mode = 1;
    for (int k = 0; k < 5; k++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      idx = 0;
`else
      idx = k % 4;
`endif
      sb_q.push_back(mk_exp(idx));
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_we("rr", w);
      // o_we, busy next cycle, idle 10 later, IDLE, then ISSUE: 13 cycles apart
      if (k == 0) check("rr_first_latency", w, 1);
      else check("rr_gap", w, 13);
    end
    req = '0;
    repeat (15) @(negedge clk);
    check("rr_sb_empty", sb_q.size(), 0);

    // Requester drops its request right after grant
    do_reset();
    tx_mode = 1;
    data[23:16] = 8'h3C;
    w0 = we_cnt;
    sb_q.push_back(mk_exp(2));
    req = 4'b0100;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (grant != '0) break;
    end
    check("drop_grant", 32'(grant), 32'(4'b0100));
    req = '0;
    data[23:16] = 8'hFF;
    repeat (30) @(negedge clk);
    check("drop_one_we", we_cnt - w0, 1);
    check("drop_sb_empty", sb_q.size(), 0);
    data = {8'hD4, 8'hC3, 8'hB2, 8'hA5};

    // Reset during WAIT_DONE
    do_reset();
    tx_mode = 1;
    sb_q.push_back(mk_exp(1));
    req = 4'b0010;
    wait_we("midrst", w);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_grant", 32'(grant), 0);
    check("midrst_ack", 32'(ack), 0);
    check("midrst_we", 32'(we), 0);
    check("midrst_data", 32'(odata), 0);
    check("midrst_cnt", 32'(cnt), 0);
    w0 = we_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_we", we_cnt - w0, 0);
    sb_q.push_back(mk_exp(0));
    req = 4'b1111;
    wait_we("midrst_next", w);
    req = '0;
    repeat (15) @(negedge clk);
    check("midrst_sb_empty", sb_q.size(), 0);

    // Counter wrap
    do_reset();
    tx_mode = 1;
    @(negedge clk);
    preload = 1'b1;
    force dut.o_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.o_cnt;
    @(negedge clk);
    preload = 1'b0;
    check("cnt_preload", 32'(cnt), 32'h0000FFFF);
    sb_q.push_back(mk_exp(0));
    req = 4'b0001;
    wait_we("wrap", w);
    req = '0;
    @(negedge clk);
    check("cnt_wrap", 32'(cnt), 0);
    repeat (15) @(negedge clk);

    check("final_sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
